// File: rtl/orv64_ob_pkg.sv
// Shared types and helpers for the orv64 outbound responder.
// Holds FSM state, request capture and address-region decode.
package orv64_ob_pkg;

  localparam int unsigned OB_ADDR_W = 40;
  localparam int unsigned OB_DATA_W = 64;
  localparam int unsigned OB_ID_W   = 6;

  typedef enum logic [1:0] {
    OB_IDLE,
    OB_BUSY,
    OB_RESP
  } ob_state_e;

  typedef enum logic {
    OB_PORT_D = 1'b0,
    OB_PORT_I = 1'b1
  } ob_port_e;

  typedef enum logic [1:0] {
    OB_RGN_TOHOST,
    OB_RGN_FROMHOST,
    OB_RGN_MAGIC,
    OB_RGN_UNMAPPED
  } ob_region_e;

  typedef struct packed {
    logic                 rwn;
    logic [OB_ADDR_W-1:0] addr;
    logic [OB_DATA_W-1:0] wdata;
    logic [OB_ID_W-1:0]   id;
    ob_port_e             port;
  } ob_req_t;

  // Mailbox addresses win over the magic window; window is [start, end).
  function automatic ob_region_e ob_decode(
    input logic [OB_ADDR_W-1:0] addr,
    input logic [OB_ADDR_W-1:0] magic_start,
    input logic [OB_ADDR_W-1:0] magic_end,
    input logic [OB_ADDR_W-1:0] to_host_addr,
    input logic [OB_ADDR_W-1:0] from_host_addr
  );
    ob_region_e rgn;
    if (addr == to_host_addr) begin
      rgn = OB_RGN_TOHOST;
    end else if (addr == from_host_addr) begin
      rgn = OB_RGN_FROMHOST;
    end else if ((addr >= magic_start) && (addr < magic_end)) begin
      rgn = OB_RGN_MAGIC;
    end else begin
      rgn = OB_RGN_UNMAPPED;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/orv64_ob_magic_mem.sv
// Magic memory backing store: MEM_WORDS x 64-bit single-port RAM.
// Read data appears one cycle after the index is presented; contents are never reset.
module orv64_ob_magic_mem #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] idx,
  input  logic [63:0]                  wdata,
  output logic [63:0]                  rdata
);

  logic [63:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/orv64_ob_responder.sv
// Outbound responder: arbitrates D/I requests round-robin and serves magic memory
// plus the tohost/fromhost mailboxes with a fixed grant-to-response latency.
module orv64_ob_responder
  import orv64_ob_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 2,
  parameter int unsigned MEM_WORDS    = 64
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 dc2ob_req,
  input  logic                 dc2ob_rwn,
  input  logic [OB_ADDR_W-1:0] dc2ob_addr,
  input  logic [63:0]          dc2ob_wdata,
  output logic [63:0]          ob2dc_rdata,
  output logic                 ob2dc_resp,

  input  logic                 ic2ob_req,
  input  logic                 ic2ob_rwn,
  input  logic [OB_ADDR_W-1:0] ic2ob_addr,
  input  logic [63:0]          ic2ob_wdata,
  input  logic [OB_ID_W-1:0]   ic2ob_id,
  output logic [63:0]          ob2ic_rdata,
  output logic                 ob2ic_resp,

  input  logic [OB_ADDR_W-1:0] cfg_magicmem_start_addr,
  input  logic [OB_ADDR_W-1:0] cfg_magicmem_end_addr,
  input  logic [OB_ADDR_W-1:0] cfg_to_host_addr,
  input  logic [OB_ADDR_W-1:0] cfg_from_host_addr,

  output logic                 tohost_valid,
  output logic [63:0]          tohost_data,
  input  logic                 tohost_ack,

  input  logic                 fromhost_wr,
  input  logic [63:0]          fromhost_wdata,
  output logic                 fromhost_valid
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam bit          LAT1      = (RESP_LATENCY == 1);
  localparam int          BUSY_CNT  = (RESP_LATENCY >= 2) ? int'(RESP_LATENCY) - 2 : 0;
  localparam logic [3:0]  BUSY_INIT = BUSY_CNT[3:0];

  ob_state_e             state_q;
  logic [3:0]            cnt_q;
  ob_port_e              prio_q;
  ob_req_t               cur_q;
  logic                  rsp_mem_q;
  logic [63:0]           rsp_data_q;
  logic [63:0]           fromhost_data;
  logic [15:0]           unmapped_cnt;

  logic                  any_req;
  logic                  gnt_i;
  ob_req_t               in_req;
  ob_req_t               nxt;
  ob_region_e            region;
  logic                  is_write;
  logic                  stall;
  logic                  commit;
  logic [OB_ADDR_W-1:0]  mem_off;
  logic [IDX_W-1:0]      mem_idx;
  logic                  mem_we;
  logic [63:0]           mem_rdata;
  logic [63:0]           host_rdata;
  logic                  unused_bits;

  assign any_req = dc2ob_req | ic2ob_req;
  assign gnt_i   = ic2ob_req & (~dc2ob_req | (prio_q == OB_PORT_I));

  always_comb begin
    in_req = '0;
    if (gnt_i) begin
      in_req.rwn   = ic2ob_rwn;
      in_req.addr  = ic2ob_addr;
      in_req.wdata = ic2ob_wdata;
      in_req.id    = ic2ob_id;
      in_req.port  = OB_PORT_I;
    end else begin
      in_req.rwn   = dc2ob_rwn;
      in_req.addr  = dc2ob_addr;
      in_req.wdata = dc2ob_wdata;
      in_req.id    = '0;
      in_req.port  = OB_PORT_D;
    end
  end

  // In IDLE the live request is decoded so a latency-1 grant can complete at once;
  // otherwise the captured request drives decode and the RAM index.
  assign nxt      = (state_q == OB_IDLE) ? in_req : cur_q;
  assign region   = ob_decode(nxt.addr, cfg_magicmem_start_addr, cfg_magicmem_end_addr,
                              cfg_to_host_addr, cfg_from_host_addr);
  assign is_write = ~nxt.rwn;
  assign stall    = (region == OB_RGN_TOHOST) & is_write & tohost_valid & ~tohost_ack;

  assign commit = ~rst & ~stall &
                  (((state_q == OB_IDLE) & any_req & LAT1) |
                   ((state_q == OB_BUSY) & (cnt_q == 4'd0)));

  assign mem_off = nxt.addr - cfg_magicmem_start_addr;
  assign mem_idx = mem_off[3 +: IDX_W];
  assign mem_we  = commit & (region == OB_RGN_MAGIC) & is_write;

  assign unused_bits = ^{mem_off[2:0], mem_off[OB_ADDR_W-1:3+IDX_W], nxt.id};

  always_comb begin
    host_rdata = '0;
    if (nxt.rwn) begin
      case (region)
        OB_RGN_TOHOST:   host_rdata = tohost_data;
        OB_RGN_FROMHOST: host_rdata = fromhost_data;
        default:         host_rdata = '0;
      endcase
    end
  end

  orv64_ob_magic_mem #(
    .MEM_WORDS(MEM_WORDS)
  ) u_magic_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (nxt.wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= OB_IDLE;
      cnt_q          <= '0;
      prio_q         <= OB_PORT_D;
      cur_q          <= '0;
      ob2dc_resp     <= 1'b0;
      ob2ic_resp     <= 1'b0;
      rsp_mem_q      <= 1'b0;
      rsp_data_q     <= '0;
      tohost_valid   <= 1'b0;
      tohost_data    <= '0;
      fromhost_valid <= 1'b0;
      fromhost_data  <= '0;
      unmapped_cnt   <= '0;
    end else begin
      ob2dc_resp <= 1'b0;
      ob2ic_resp <= 1'b0;

      unique case (state_q)
        OB_IDLE: begin
          if (any_req) begin
            cur_q   <= in_req;
            prio_q  <= gnt_i ? OB_PORT_D : OB_PORT_I;
            cnt_q   <= BUSY_INIT;
            state_q <= commit ? OB_RESP : OB_BUSY;
          end
        end
        OB_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (commit) begin
            state_q <= OB_RESP;
          end
        end
        OB_RESP: state_q <= OB_IDLE;
        default: state_q <= OB_IDLE;
      endcase

      if (commit) begin
        ob2dc_resp <= (nxt.port == OB_PORT_D);
        ob2ic_resp <= (nxt.port == OB_PORT_I);
        rsp_mem_q  <= (region == OB_RGN_MAGIC) & nxt.rwn;
        rsp_data_q <= host_rdata;
        if ((region == OB_RGN_UNMAPPED) && (unmapped_cnt != '1)) begin
          unmapped_cnt <= unmapped_cnt + 16'd1;
        end
      end

      // A completing write beats a same-cycle ack, so valid stays set with new data.
      if (commit && (region == OB_RGN_TOHOST) && is_write) begin
        tohost_data  <= nxt.wdata;
        tohost_valid <= 1'b1;
      end else if (tohost_ack) begin
        tohost_valid <= 1'b0;
      end

      if (fromhost_wr) begin
        fromhost_data  <= fromhost_wdata;
        fromhost_valid <= 1'b1;
      end else if (commit && (region == OB_RGN_FROMHOST) && is_write) begin
        fromhost_valid <= 1'b0;
      end
    end
  end

  assign ob2dc_rdata = ob2dc_resp ? (rsp_mem_q ? mem_rdata : rsp_data_q) : '0;
  assign ob2ic_rdata = ob2ic_resp ? (rsp_mem_q ? mem_rdata : rsp_data_q) : '0;

endmodule
